// File: rtl/node_input_sequencer_if.sv
// Sample stream into the node input sequencer: upstream drives valid/data,
// the sequencer answers with ready.
interface node_input_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/node_input_sequencer.sv
// Collects one frame of N_INPUTS samples into a local buffer, then sweeps
// cnt_val across the buffer one index per clock for the node's MAC,
// bracketed by a clear strobe before and a done strobe after.
module node_input_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_INPUTS = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               frame_start,
    input  logic                               abort,
    node_input_sequencer_if.slave              in_if,
    output logic [N_INPUTS-1:0][DATA_W-1:0]    data_out,
    output logic [CNT_W-1:0]                   cnt_val,
    output logic                               mac_clr,
    output logic                               mac_en,
    output logic                               done,
    output logic                               busy
);

    localparam int unsigned      IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        SWEEP,
        DONE
    } state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [N_INPUTS-1:0][DATA_W-1:0]   buf_q, buf_d;
    logic                              in_ready_q, in_ready_d;
    logic                              mac_clr_q, mac_clr_d;
    logic                              mac_en_q, mac_en_d;
    logic                              done_q, done_d;
    logic                              busy_q, busy_d;
    logic                              accept;

    // in_ready_q is high exactly while in LOAD, so it doubles as the state qualifier
    assign accept = in_ready_q & in_if.in_valid;

    // State, counters, buffer and registered strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            in_ready_q <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            in_ready_q <= in_ready_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next state, write pointer, sweep index and buffer writes; abort overrides all
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    buf_d[wr_ptr_q[IDX_W-1:0]] = in_if.in_data;
                    if (wr_ptr_q == LAST) begin
                        state_d  = CLEAR;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    end
                end
            end
            CLEAR: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
            SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort cancels any pending accept, keeps the buffer, and also blocks frame_start in IDLE
        if (abort) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            cnt_d    = '0;
            buf_d    = buf_q;
        end
    end

    // Strobes decoded from the next state so they register alongside it
    always_comb begin
        in_ready_d = (state_d == LOAD);
        mac_clr_d  = (state_d == CLEAR);
        mac_en_d   = (state_d == SWEEP);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    assign in_if.in_ready = in_ready_q;
    assign data_out       = buf_q;
    assign cnt_val        = cnt_q;
    assign mac_clr        = mac_clr_q;
    assign mac_en         = mac_en_q;
    assign done           = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_node_input_sequencer.sv
// Scoreboard bench for node_input_sequencer: stimulus queues the expected
// (cnt_val, data_out[cnt_val]) pairs for every sweep cycle and the expected
// done pulses; a negedge monitor pops and compares as the DUT sweeps.
module tb_node_input_sequencer;

    localparam int DATA_W = 16;
    localparam int N      = 64;
    localparam int CNT_W  = 7;

    typedef struct {
        int          cnt;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic frame_start = 1'b0;
    logic abort = 1'b0;

    logic [N-1:0][DATA_W-1:0] data_out;
    logic [CNT_W-1:0]         cnt_val;
    logic mac_clr, mac_en, done, busy;

    node_input_sequencer_if #(.DATA_W(DATA_W)) in_if ();

    node_input_sequencer #(
        .DATA_W  (DATA_W),
        .N_INPUTS(N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_start(frame_start),
        .abort      (abort),
        .in_if      (in_if.slave),
        .data_out   (data_out),
        .cnt_val    (cnt_val),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   done_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] base, input int n_entries, input bit with_done);
        for (int i = 0; i < n_entries; i++) begin
            exp_t e;
            e.cnt  = i;
            e.data = base + 16'(i);
            exp_q.push_back(e);
        end
        if (with_done) done_exp++;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", in_if.in_ready, 1);
    endtask

    task automatic send_word(input logic [15:0] d);
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        for (int k = 0; k < 50; k++) begin
            if (in_if.in_ready) break;
            tick();
        end
        if (!in_if.in_ready) check("accept_timeout", 0, 1);
        tick();
    endtask

    task automatic send_b2b(input logic [15:0] base);
        for (int i = 0; i < N; i++) send_word(base + 16'(i));
        check("clear_after_last", mac_clr, 1);
        check("ready_low_in_clear", in_if.in_ready, 0);
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            tick();
        end
        check("done_seen", done, 1);
        check("busy_during_done", busy, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("cnt_after_done", cnt_val, 0);
    endtask

    // Monitor: compare every sweep cycle and done pulse against the scoreboard
    logic             prev_en = 1'b0;
    logic             prev_clr = 1'b0;
    logic [CNT_W-1:0] prev_cnt = '0;
    exp_t             m_e;
    always @(negedge clk) begin
        if (mac_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_mac_en", 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                check("sweep_cnt", 32'(cnt_val), m_e.cnt);
                check("sweep_data", 32'(data_out[cnt_val[5:0]]), 32'(m_e.data));
            end
            if (!prev_en) check("clr_before_sweep", prev_clr, 1);
        end
        if (done) begin
            if (done_exp == 0) check("unexpected_done", 1, 0);
            else done_exp--;
            check("done_after_last", {prev_en, prev_cnt}, {1'b1, 7'd63});
        end
        prev_en  = mac_en;
        prev_clr = mac_clr;
        prev_cnt = cnt_val;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with in_valid asserted
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'hFFFF;
        n_rst = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_if.in_ready, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt_val, 0);
        check("rst_buffer", (data_out == '0), 1);
        n_rst = 1'b1;
        repeat (3) tick();
        check("idle_ready", in_if.in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_ignores_valid", (data_out == '0), 1);
        in_if.in_valid = 1'b0;

        // frame_start with abort in IDLE stays IDLE
        frame_start = 1'b1;
        abort = 1'b1;
        tick();
        frame_start = 1'b0;
        abort = 1'b0;
        tick();
        check("start_abort_idle", busy, 0);

        // Full back-to-back frame
        push_frame(16'h0100, N, 1'b1);
        start_frame();
        send_b2b(16'h0100);
        tick();
        check("clear_one_cycle", mac_clr, 0);
        check("sweep_starts", mac_en, 1);
        wait_done();

        // Gappy stream with junk data on the idle cycles
        push_frame(16'h0300, N, 1'b1);
        start_frame();
        for (int i = 0; i < N; i++) begin
            in_if.in_valid = 1'b0;
            in_if.in_data  = 16'hDEAD;
            tick();
            if (i == N - 1) begin
                check("no_clear_before_last", mac_clr, 0);
                check("ready_before_last", in_if.in_ready, 1);
            end
            send_word(16'h0300 + 16'(i));
        end
        check("gappy_clear", mac_clr, 1);
        in_if.in_valid = 1'b0;
        wait_done();

        // Abort on the 30th accept: that word is dropped, buffer otherwise kept
        start_frame();
        for (int i = 0; i < 29; i++) send_word(16'h0400 + 16'(i));
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'h041D;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_if.in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", in_if.in_ready, 0);
        check("abort_cnt", cnt_val, 0);
        check("abort_buf28", 32'(data_out[28]), 32'h041C);
        check("abort_buf29_kept", 32'(data_out[29]), 32'h031D);
        repeat (3) tick();
        check("abort_no_done", done, 0);
        push_frame(16'h0500, N, 1'b1);
        start_frame();
        send_b2b(16'h0500);
        wait_done();

        // frame_start and in_valid during SWEEP are ignored
        push_frame(16'h0600, N, 1'b1);
        start_frame();
        send_b2b(16'h0600);
        repeat (4) tick();
        frame_start    = 1'b1;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'hBEEF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("sweep_ready_low", in_if.in_ready, 0);
        end
        frame_start    = 1'b0;
        in_if.in_valid = 1'b0;
        wait_done();
        tick();
        check("frame_start_ignored", busy, 0);

        // Asynchronous reset at cnt_val == 40
        push_frame(16'h0700, 40, 1'b0);
        start_frame();
        send_b2b(16'h0700);
        for (int k = 0; k < 200; k++) begin
            if (cnt_val == 7'd40) break;
            tick();
        end
        check("reached_cnt40", cnt_val, 40);
        n_rst = 1'b0;
        #1;
        check("arst_mac_en", mac_en, 0);
        check("arst_busy", busy, 0);
        check("arst_cnt", cnt_val, 0);
        check("arst_buffer", (data_out == '0), 1);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        push_frame(16'h0800, N, 1'b1);
        start_frame();
        send_b2b(16'h0800);
        wait_done();

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_all_seen", done_exp, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
